// File: rtl/msdap_output_receiver_pkg.sv
// Shared constants and types for the MSDAP output receiver slice.
package msdap_output_receiver_pkg;

  localparam int unsigned WORD_W    = 40;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned BIT_CNT_W = $clog2(WORD_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] l;
    logic [WORD_W-1:0] r;
  } pair_t;

endpackage

// File: rtl/msdap_output_receiver_if.sv
// Serial input pins plus the sample-side handshake of the MSDAP receiver.
interface msdap_output_receiver_if;
  import msdap_output_receiver_pkg::*;

  logic              Frame;
  logic              OutReady;
  logic              OutputL;
  logic              OutputR;
  logic [WORD_W-1:0] sample_L;
  logic [WORD_W-1:0] sample_R;
  logic              sample_valid;
  logic              sample_ready;
  logic              frame_error;
  logic              overflow;
  logic [CNT_W-1:0]  sample_count;

  modport master (
    output Frame, OutReady, OutputL, OutputR, sample_ready,
    input  sample_L, sample_R, sample_valid, frame_error, overflow, sample_count
  );

  modport slave (
    input  Frame, OutReady, OutputL, OutputR, sample_ready,
    output sample_L, sample_R, sample_valid, frame_error, overflow, sample_count
  );

endinterface

// File: rtl/msdap_pair_fifo.sv
// Two-entry {L,R} FIFO; entry 0 is always the head and empty slots hold zero.
module msdap_pair_fifo
  import msdap_output_receiver_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  pair_t din,
  output pair_t head,
  output logic  valid,
  output logic  full,
  output logic  drop_c
);

  pair_t entry0, entry1;
  logic  occ0, occ1;
  logic  doPop;

  assign doPop  = pop & occ0;
  assign drop_c = push & occ1 & ~doPop;
  assign head   = entry0;
  assign valid  = occ0;
  assign full   = occ1;

  // Shift-style storage so the head register feeds the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      occ0   <= 1'b0;
      occ1   <= 1'b0;
    end else begin
      case ({push, doPop})
        2'b10: begin
          if (!occ0) begin
            entry0 <= din;
            occ0   <= 1'b1;
          end else if (!occ1) begin
            entry1 <= din;
            occ1   <= 1'b1;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          occ0   <= occ1;
          entry1 <= '0;
          occ1   <= 1'b0;
        end
        2'b11: begin
          if (occ1) begin
            entry0 <= entry1;
            entry1 <= din;
          end else begin
            entry0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/msdap_output_receiver.sv
// Deserializes MSDAP OutputL/OutputR words and queues L/R pairs for the host.
module msdap_output_receiver
  import msdap_output_receiver_pkg::*;
(
  input  logic                    Sclk,
  input  logic                    Reset_n,
  msdap_output_receiver_if.slave  bus
);

  state_t                state, stateNext;
  logic [BIT_CNT_W-1:0]  bitCnt, bitCntNext;
  logic [WORD_W-1:0]     shiftL, shiftLNext;
  logic [WORD_W-1:0]     shiftR, shiftRNext;
  logic                  pushWord;
  logic                  frameErrNext;
  logic                  frameErr;
  logic                  overflowReg;
  logic [CNT_W-1:0]      pairCount;
  pair_t                 headPair;
  logic                  fifoValid;
  logic                  fifoFull;
  logic                  dropC;

  // State, bit counter and shift registers.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      bitCnt <= '0;
      shiftL <= '0;
      shiftR <= '0;
    end else begin
      state  <= stateNext;
      bitCnt <= bitCntNext;
      shiftL <= shiftLNext;
      shiftR <= shiftRNext;
    end
  end

  // Framing FSM: start on Frame, shift WORD_W bits, discard on any framing fault.
  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    shiftLNext   = shiftL;
    shiftRNext   = shiftR;
    pushWord     = 1'b0;
    frameErrNext = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Frame && bus.OutReady) begin
          shiftLNext = {(WORD_W-1)'(0), bus.OutputL};
          shiftRNext = {(WORD_W-1)'(0), bus.OutputR};
          bitCntNext = BIT_CNT_W'(1);
          stateNext  = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.OutReady) begin
          // OutReady loss wins over a coincident Frame.
          frameErrNext = 1'b1;
          shiftLNext   = '0;
          shiftRNext   = '0;
          bitCntNext   = '0;
          stateNext    = IDLE;
        end else if (bus.Frame) begin
          // Restart: this bit becomes the MSB of a new word.
          frameErrNext = 1'b1;
          shiftLNext   = {(WORD_W-1)'(0), bus.OutputL};
          shiftRNext   = {(WORD_W-1)'(0), bus.OutputR};
          bitCntNext   = BIT_CNT_W'(1);
        end else begin
          shiftLNext = {shiftL[WORD_W-2:0], bus.OutputL};
          shiftRNext = {shiftR[WORD_W-2:0], bus.OutputR};
          if (bitCnt == BIT_CNT_W'(WORD_W-1)) begin
            pushWord   = 1'b1;
            bitCntNext = '0;
            stateNext  = IDLE;
          end else begin
            bitCntNext = bitCnt + BIT_CNT_W'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Status flags: error pulse, sticky overflow, completed-pair counter.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      frameErr    <= 1'b0;
      overflowReg <= 1'b0;
      pairCount   <= '0;
    end else begin
      frameErr    <= frameErrNext;
      overflowReg <= overflowReg | dropC;
      if (pushWord) pairCount <= pairCount + CNT_W'(1);
    end
  end

  msdap_pair_fifo u_fifo (
    .clk    (Sclk),
    .rst_n  (Reset_n),
    .push   (pushWord),
    .pop    (bus.sample_ready),
    .din    ({shiftLNext, shiftRNext}),
    .head   (headPair),
    .valid  (fifoValid),
    .full   (fifoFull),
    .drop_c (dropC)
  );

  assign bus.sample_L     = headPair.l;
  assign bus.sample_R     = headPair.r;
  assign bus.sample_valid = fifoValid;
  assign bus.frame_error  = frameErr;
  assign bus.overflow     = overflowReg;
  assign bus.sample_count = pairCount;

  logic unusedFull;
  assign unusedFull = fifoFull;

endmodule

// File: tb/tb_msdap_output_receiver.sv
// Directed bench for msdap_output_receiver.
module tb_msdap_output_receiver;
  import msdap_output_receiver_pkg::*;

  logic Sclk = 1'b0;
  logic Reset_n;
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   feCount     = 0;
  int   feBase;

  msdap_output_receiver_if bus ();

  msdap_output_receiver dut (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Sclk = ~Sclk;

  // Count frame_error pulses, sampled mid-cycle.
  always @(negedge Sclk) if (bus.frame_error === 1'b1) feCount++;

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    bus.Frame    = 1'b0;
    bus.OutReady = 1'b0;
    bus.OutputL  = 1'b0;
    bus.OutputR  = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    tick();
  endtask

  // Full word, MSB first; optionally raise sample_ready on the bit-0 cycle.
  task automatic sendWord(input logic [WORD_W-1:0] l, input logic [WORD_W-1:0] r, input bit popLast);
    for (int i = 0; i < int'(WORD_W); i++) begin
      bus.Frame    = (i == 0);
      bus.OutReady = 1'b1;
      bus.OutputL  = l[WORD_W-1-i];
      bus.OutputR  = r[WORD_W-1-i];
      if (popLast && i == int'(WORD_W) - 1) bus.sample_ready = 1'b1;
      tick();
    end
    idleInputs();
  endtask

  // First n bits of a word that is never finished.
  task automatic partialWord(input int n);
    for (int i = 0; i < n; i++) begin
      bus.Frame    = (i == 0);
      bus.OutReady = 1'b1;
      bus.OutputL  = i[0];
      bus.OutputR  = ~i[0];
      tick();
    end
  endtask

  initial begin
    idleInputs();
    bus.sample_ready = 1'b1;
    Reset_n = 1'b0;
    tick();
    tick();
    check("rst_valid", WORD_W'(bus.sample_valid), '0);
    check("rst_L", bus.sample_L, '0);
    check("rst_R", bus.sample_R, '0);
    check("rst_ferr", WORD_W'(bus.frame_error), '0);
    check("rst_ovf", WORD_W'(bus.overflow), '0);
    check("rst_cnt", WORD_W'(bus.sample_count), '0);
    @(negedge Sclk);
    Reset_n = 1'b1;
    tick();

    // Single word, consumer always ready.
    feBase = feCount;
    sendWord(40'h80_0000_0001, 40'h7F_FFFF_FFFE, 1'b0);
    check("t1_valid", WORD_W'(bus.sample_valid), WORD_W'(1));
    check("t1_L", bus.sample_L, 40'h80_0000_0001);
    check("t1_R", bus.sample_R, 40'h7F_FFFF_FFFE);
    check("t1_cnt", WORD_W'(bus.sample_count), WORD_W'(1));
    tick();
    check("t1_valid_fall", WORD_W'(bus.sample_valid), '0);
    check("t1_L_empty", bus.sample_L, '0);
    check("t1_no_ferr", WORD_W'(feCount - feBase), '0);

    // Idle Frame without OutReady is ignored.
    feBase = feCount;
    bus.Frame = 1'b1;
    tick();
    bus.Frame = 1'b0;
    tick();
    tick();
    check("idle_frame_ferr", WORD_W'(feCount - feBase), '0);

    // Back-to-back words into a stalled consumer; third dropped.
    doReset();
    bus.sample_ready = 1'b0;
    sendWord(40'd1, ~40'd1, 1'b0);
    sendWord(40'd2, ~40'd2, 1'b0);
    sendWord(40'd3, ~40'd3, 1'b0);
    check("t2_ovf", WORD_W'(bus.overflow), WORD_W'(1));
    check("t2_cnt", WORD_W'(bus.sample_count), WORD_W'(3));
    check("t2_head_L", bus.sample_L, 40'd1);
    check("t2_head_R", bus.sample_R, 40'hFF_FFFF_FFFE);
    bus.sample_ready = 1'b1;
    tick();
    check("t2_pop1_L", bus.sample_L, 40'd2);
    check("t2_pop1_R", bus.sample_R, 40'hFF_FFFF_FFFD);
    tick();
    check("t2_empty", WORD_W'(bus.sample_valid), '0);
    check("t2_ovf_sticky", WORD_W'(bus.overflow), WORD_W'(1));

    // Frame re-asserted at bit 20 restarts the word.
    doReset();
    feBase = feCount;
    partialWord(20);
    sendWord(40'hA5A5A5A5A5, 40'h5A5A5A5A5A, 1'b0);
    check("t3_L", bus.sample_L, 40'hA5A5A5A5A5);
    check("t3_R", bus.sample_R, 40'h5A5A5A5A5A);
    check("t3_cnt", WORD_W'(bus.sample_count), WORD_W'(1));
    check("t3_ferr", WORD_W'(feCount - feBase), WORD_W'(1));
    tick();
    check("t3_only_one", WORD_W'(bus.sample_valid), '0);

    // OutReady lost at bit 10, then a clean word.
    feBase = feCount;
    partialWord(10);
    idleInputs();
    tick();
    tick();
    check("t4_ferr", WORD_W'(feCount - feBase), WORD_W'(1));
    check("t4_no_sample", WORD_W'(bus.sample_valid), '0);
    check("t4_cnt_hold", WORD_W'(bus.sample_count), WORD_W'(1));
    sendWord(40'h12_3456_789A, 40'hFE_DCBA_9876, 1'b0);
    check("t4_L", bus.sample_L, 40'h12_3456_789A);
    check("t4_R", bus.sample_R, 40'hFE_DCBA_9876);
    check("t4_cnt", WORD_W'(bus.sample_count), WORD_W'(2));
    tick();

    // Push and pop together while full.
    doReset();
    bus.sample_ready = 1'b0;
    sendWord(40'h11, 40'h22, 1'b0);
    sendWord(40'h33, 40'h44, 1'b0);
    sendWord(40'h55, 40'h66, 1'b1);
    bus.sample_ready = 1'b0;
    check("t5_no_ovf", WORD_W'(bus.overflow), '0);
    check("t5_cnt", WORD_W'(bus.sample_count), WORD_W'(3));
    check("t5_head_L", bus.sample_L, 40'h33);
    check("t5_head_R", bus.sample_R, 40'h44);
    bus.sample_ready = 1'b1;
    tick();
    check("t5_second_L", bus.sample_L, 40'h55);
    check("t5_second_R", bus.sample_R, 40'h66);
    tick();
    check("t5_drained", WORD_W'(bus.sample_valid), '0);

    // Asynchronous reset mid-word with a buffered sample.
    bus.sample_ready = 1'b0;
    sendWord(40'h0F_0F0F_0F0F, 40'hF0_F0F0_F0F0, 1'b0);
    check("t6_pre_valid", WORD_W'(bus.sample_valid), WORD_W'(1));
    partialWord(15);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t6_valid", WORD_W'(bus.sample_valid), '0);
    check("t6_L", bus.sample_L, '0);
    check("t6_R", bus.sample_R, '0);
    check("t6_cnt", WORD_W'(bus.sample_count), '0);
    idleInputs();
    @(negedge Sclk);
    Reset_n = 1'b1;
    tick();
    sendWord(40'hC3_3C5A_A5E1, 40'h1E_5AA5_C33C, 1'b0);
    check("t6_post_L", bus.sample_L, 40'hC3_3C5A_A5E1);
    check("t6_post_R", bus.sample_R, 40'h1E_5AA5_C33C);
    check("t6_post_cnt", WORD_W'(bus.sample_count), WORD_W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/msdap_output_receiver.md
Name: msdap_output_receiver

Overview:
- Host-side receiver for the MSDAP serial output pair (OutputL/OutputR).
- Deserializes each 40-bit MSB-first word framed by Frame and qualified by OutReady.
- Presents left/right sample pairs on a valid/ready interface through a 2-entry buffer.
- Flags framing faults and buffer overflow. Used in the test harness and the downstream host logic on the Sclk domain.

Parameters:
- WORD_W, 40, serial word width in bits (matches the filter accumulator width)
- CNT_W, 16, width of the received-pair counter

Ports:
- Sclk  input  1  sole clock; all sampling on the rising edge
- Reset_n  input  1  reset, asynchronous, active-low
- Frame  input  1  one-cycle pulse marking the MSB bit cycle of a word
- OutReady  input  1  high during all WORD_W bit cycles of a word
- OutputL  input  1  left serial data, MSB first
- OutputR  input  1  right serial data, MSB first
- sample_L  output  WORD_W  head-of-buffer left word
- sample_R  output  WORD_W  head-of-buffer right word
- sample_valid  output  1  buffer non-empty
- sample_ready  input  1  consumer accepts head when valid & ready
- frame_error  output  1  one-cycle pulse on a framing fault
- overflow  output  1  sticky; set when a completed word was dropped
- sample_count  output  CNT_W  completed pairs written to buffer, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, Reset_n=0):
  - FSM goes to IDLE; bit counter = 0; shift registers = 0; buffer empty.
  - sample_L/sample_R = 0, sample_valid = 0, frame_error = 0, overflow = 0, sample_count = 0.
  - Reset mid-word discards the partial word.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On an edge with Frame=1 and OutReady=1: capture OutputL/OutputR as bit WORD_W-1, set cnt = 1, go to SHIFT.
  - Frame=1 with OutReady=0: ignored, no error.
- SHIFT, each edge:
  - Shift in OutputL/OutputR and increment cnt.
  - When the edge captures bit 0 (cnt == WORD_W-1): write the assembled {L,R} pair into the buffer in the same edge, increment sample_count, go to IDLE.
  - Back-to-back: a Frame on the very next edge is accepted from IDLE with no gap cycle.
- Framing faults, each producing a frame_error pulse in the following cycle:
  - Frame=1 in SHIFT: the partial word is discarded and the current bit is taken as the MSB of a new word (cnt = 1, stay in SHIFT).
  - OutReady=0 in SHIFT: the partial word is discarded, go to IDLE.
  - If both occur on the same edge, the OutReady fault takes precedence and the FSM goes to IDLE.
- Latency: sample_valid rises in the cycle after the edge that captured bit 0, i.e. WORD_W edges after the Frame edge.
- Buffer: 2-entry FIFO; sample_L/sample_R always show the head entry, and 0 when empty.
  - Pop when sample_valid & sample_ready.
  - Push and pop on the same edge are both performed, including when the buffer is full.
  - Push when full without a pop: the new pair is dropped, overflow is set (sticky until reset), the buffer is unchanged, and sample_count still increments.
- sample_ready while empty has no effect.
- The data path is bit-exact: no sign extension or arithmetic; words are transferred unmodified.

Decomposition:
- Shared package:
  - WORD_W default constant (40), shared with the transmit-side PISO.
  - FSM state enum {IDLE, SHIFT}.
- One natural sub-module: msdap_pair_fifo, a 2-entry {L,R} FIFO with push/pop/full/empty and drop-on-full. The FSM and shift registers stay in the top module.

Test Plan:
- Single word: Frame at edge 0, L = 40'h80_0000_0001, R = 40'h7F_FFFF_FFFE shifted MSB first, sample_ready=1 → sample_valid high for one cycle after edge 39 with those exact values; sample_count = 1; frame_error never asserted.
- Back-to-back: 3 words with Frame every 40 edges, L = 1, 2, 3 and R = ~L, sample_ready=0 → first two pairs buffered in order, third pair dropped, overflow = 1, sample_count = 3; popping then returns pairs 1 then 2, and sample_valid falls.
- Mid-word Frame: Frame re-asserted at bit 20, then a full word L = 40'hA5A5A5A5A5 follows → one frame_error pulse; only 40'hA5A5A5A5A5 is delivered; sample_count = 1.
- OutReady drop: OutReady low at bit 10 → frame_error pulse, FSM returns to IDLE, no sample delivered; the next clean word is received correctly.
- Simultaneous push/pop when full: buffer holds 2 entries, sample_ready=1 on the edge where a third word completes → no overflow; order preserved; 2 entries remain.
- Async reset: Reset_n pulled low mid-word, asynchronous to Sclk → all outputs 0 immediately; after release, the next framed word is received intact.
